// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU (A)
// and load (B) writeback paths, each buffered by a single-entry holding slot.
module regfile_wb_arbiter #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic              busy
);

  localparam logic ZS_EN = (ZERO_SUPPRESS != 0);

  logic              a_hold_v_q, a_hold_v_d;
  logic [ADDR_W-1:0] a_hold_addr_q, a_hold_addr_d;
  logic [DATA_W-1:0] a_hold_data_q, a_hold_data_d;
  logic              b_hold_v_q, b_hold_v_d;
  logic [ADDR_W-1:0] b_hold_addr_q, b_hold_addr_d;
  logic [DATA_W-1:0] b_hold_data_q, b_hold_data_d;
  logic              last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic              grant_a, grant_b;
  logic              a_xfer, b_xfer;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Grant from held state only; on an address clash A goes first so B's value lands last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case ({a_hold_v_q, b_hold_v_q})
      2'b10: grant_a = 1'b1;
      2'b01: grant_b = 1'b1;
      2'b11: begin
        if (a_hold_addr_q == b_hold_addr_q) begin
          grant_a = 1'b1;
        end else if (last_grant_q) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  assign a_ready = !flush && (!a_hold_v_q || grant_a);
  assign b_ready = !flush && (!b_hold_v_q || grant_b);
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;
  assign busy    = a_hold_v_q || b_hold_v_q;

  // Mux the granted slot toward the output registers.
  always_comb begin
    gnt_addr = a_hold_addr_q;
    gnt_data = a_hold_data_q;
    if (grant_b) begin
      gnt_addr = b_hold_addr_q;
      gnt_data = b_hold_data_q;
    end else begin
      gnt_addr = a_hold_addr_q;
      gnt_data = a_hold_data_q;
    end
  end

  // Next-state: slot drain/refill, output update, round-robin pointer.
  always_comb begin
    a_hold_v_d    = a_hold_v_q;
    a_hold_addr_d = a_hold_addr_q;
    a_hold_data_d = a_hold_data_q;
    b_hold_v_d    = b_hold_v_q;
    b_hold_addr_d = b_hold_addr_q;
    b_hold_data_d = b_hold_data_q;
    last_grant_d  = last_grant_q;
    reg_write_d   = 1'b0;
    write_reg_d   = write_reg_q;
    write_data_d  = write_data_q;
    if (flush) begin
      a_hold_v_d  = 1'b0;
      b_hold_v_d  = 1'b0;
      reg_write_d = 1'b0;
    end else begin
      if (grant_a || grant_b) begin
        reg_write_d  = !(ZS_EN && (gnt_addr == {ADDR_W{1'b0}}));
        write_reg_d  = gnt_addr;
        write_data_d = gnt_data;
        last_grant_d = grant_b;
      end else begin
        reg_write_d = 1'b0;
      end
      if (grant_a) begin
        a_hold_v_d = 1'b0;
      end else begin
        a_hold_v_d = a_hold_v_q;
      end
      if (grant_b) begin
        b_hold_v_d = 1'b0;
      end else begin
        b_hold_v_d = b_hold_v_q;
      end
      // A refill on the grant edge overrides the clear above.
      if (a_xfer) begin
        a_hold_v_d    = 1'b1;
        a_hold_addr_d = a_addr;
        a_hold_data_d = a_data;
      end else begin
        a_hold_addr_d = a_hold_addr_q;
      end
      if (b_xfer) begin
        b_hold_v_d    = 1'b1;
        b_hold_addr_d = b_addr;
        b_hold_data_d = b_data;
      end else begin
        b_hold_addr_d = b_hold_addr_q;
      end
    end
  end

  // State registers; last_grant resets to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_hold_v_q    <= 1'b0;
      a_hold_addr_q <= {ADDR_W{1'b0}};
      a_hold_data_q <= {DATA_W{1'b0}};
      b_hold_v_q    <= 1'b0;
      b_hold_addr_q <= {ADDR_W{1'b0}};
      b_hold_data_q <= {DATA_W{1'b0}};
      last_grant_q  <= 1'b1;
      reg_write_q   <= 1'b0;
      write_reg_q   <= {ADDR_W{1'b0}};
      write_data_q  <= {DATA_W{1'b0}};
    end else begin
      a_hold_v_q    <= a_hold_v_d;
      a_hold_addr_q <= a_hold_addr_d;
      a_hold_data_q <= a_hold_data_d;
      b_hold_v_q    <= b_hold_v_d;
      b_hold_addr_q <= b_hold_addr_d;
      b_hold_data_q <= b_hold_data_d;
      last_grant_q  <= last_grant_d;
      reg_write_q   <= reg_write_d;
      write_reg_q   <= write_reg_d;
      write_data_q  <= write_data_d;
    end
  end

  assign regWrite      = reg_write_q;
  assign writeRegister = write_reg_q;
  assign writeData     = write_data_q;

endmodule
